// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: word size, reset PC default and fetch FSM encodings.
package fetch_unit_pkg;

    localparam int          WORD_SIZE        = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'b00,
        FETCH_REQ    = 2'b01,
        FETCH_HOLD   = 2'b10,
        FETCH_HALTED = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read bus plus the downstream instruction handshake of the fetch stage.
interface fetch_unit_if import fetch_unit_pkg::*; #(parameter int WORD = WORD_SIZE);

    logic            readM;
    logic [WORD-1:0] address;
    logic [WORD-1:0] mem_data;
    logic            mem_ready;
    logic            inst_valid;
    logic [WORD-1:0] inst;
    logic [WORD-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output readM, address, inst_valid, inst, inst_pc,
        input  mem_data, mem_ready, inst_ready
    );

    modport slave (
        input  readM, address, inst_valid, inst, inst_pc,
        output mem_data, mem_ready, inst_ready
    );

endinterface

// File: rtl/fetch_unit_inst_buffer.sv
// Fetched-instruction holding register; FETCH_PREFETCH_EN adds a second (prefetch) entry behind it.
module fetch_unit_inst_buffer import fetch_unit_pkg::*; #(
    parameter int WORD = WORD_SIZE
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [WORD-1:0] push_data,
    input  logic [WORD-1:0] push_pc,
    output logic [WORD-1:0] head_data,
    output logic [WORD-1:0] head_pc,
    output logic            empty,
    output logic            full
);

    logic            head_valid_q, head_valid_d;
    logic [WORD-1:0] head_data_q, head_data_d;
    logic [WORD-1:0] head_pc_q, head_pc_d;
`ifdef FETCH_PREFETCH_EN
    logic            tail_valid_q, tail_valid_d;
    logic [WORD-1:0] tail_data_q, tail_data_d;
    logic [WORD-1:0] tail_pc_q, tail_pc_d;
`endif

    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_pc_d    = head_pc_q;
`ifdef FETCH_PREFETCH_EN
        tail_valid_d = tail_valid_q;
        tail_data_d  = tail_data_q;
        tail_pc_d    = tail_pc_q;
        if (flush) begin
            head_valid_d = 1'b0;
            tail_valid_d = 1'b0;
        end else begin
            if (pop) begin
                head_valid_d = tail_valid_q;
                if (tail_valid_q) begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                end
                tail_valid_d = 1'b0;
            end
            // A push lands in the head if the pop just vacated it, else behind it.
            if (push) begin
                if (!head_valid_d) begin
                    head_valid_d = 1'b1;
                    head_data_d  = push_data;
                    head_pc_d    = push_pc;
                end else begin
                    tail_valid_d = 1'b1;
                    tail_data_d  = push_data;
                    tail_pc_d    = push_pc;
                end
            end
        end
`else
        if (flush) begin
            head_valid_d = 1'b0;
        end else if (push) begin
            head_valid_d = 1'b1;
            head_data_d  = push_data;
            head_pc_d    = push_pc;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_pc_q    <= '0;
`ifdef FETCH_PREFETCH_EN
            tail_valid_q <= 1'b0;
            tail_data_q  <= '0;
            tail_pc_q    <= '0;
`endif
        end else begin
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_pc_q    <= head_pc_d;
`ifdef FETCH_PREFETCH_EN
            tail_valid_q <= tail_valid_d;
            tail_data_q  <= tail_data_d;
            tail_pc_q    <= tail_pc_d;
`endif
        end
    end

    assign head_data = head_data_q;
    assign head_pc   = head_pc_q;
    assign empty     = !head_valid_q;
`ifdef FETCH_PREFETCH_EN
    assign full      = head_valid_q && tail_valid_q;
`else
    assign full      = head_valid_q;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads memory when granted, hands words downstream.
// Optional FETCH_PREFETCH_EN overlaps the next read with a held instruction.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int              WORD     = WORD_SIZE,
    parameter logic [WORD-1:0] RESET_PC = WORD'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            bus_grant,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    input  logic            halt,
    output logic [WORD-1:0] num_inst,
    output logic            is_halted,
    fetch_unit_if.master    bus
);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] num_inst_q, num_inst_d;
    logic            discard_q, discard_d;
    logic            halt_pend_q, halt_pend_d;
    logic            push, pop, flush, next_empty;
    logic            buf_empty, buf_full;
    logic [WORD-1:0] head_data, head_pc;
    logic            read_req, mem_done, handshake;

`ifdef FETCH_PREFETCH_EN
    logic pf_busy_q, pf_busy_d, issue_now;
    // The prefetch read is raised in the same HOLD cycle so back-to-back delivery is possible.
    assign issue_now = (state_q == FETCH_HOLD) && !pf_busy_q && !buf_full && bus_grant
                       && !halt && !redirect;
    assign read_req  = (state_q == FETCH_REQ) || pf_busy_q || issue_now;
`else
    assign read_req  = (state_q == FETCH_REQ);
`endif

    assign mem_done  = read_req && bus.mem_ready;
    assign handshake = !buf_empty && bus.inst_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        num_inst_d  = num_inst_q;
        discard_d   = discard_q;
        halt_pend_d = halt_pend_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        next_empty  = 1'b0;
`ifdef FETCH_PREFETCH_EN
        pf_busy_d   = pf_busy_q;
`endif
        if (state_q == FETCH_HALTED) begin
            state_d = FETCH_HALTED;
        end else if (halt || halt_pend_q) begin
            // An outstanding read must still complete before the bus is released.
            flush = 1'b1;
`ifdef FETCH_PREFETCH_EN
            pf_busy_d = 1'b0;
`endif
            if (read_req && !bus.mem_ready) begin
                state_d     = FETCH_REQ;
                halt_pend_d = 1'b1;
            end else begin
                state_d     = FETCH_HALTED;
                halt_pend_d = 1'b0;
                discard_d   = 1'b0;
            end
        end else if (redirect) begin
            flush = 1'b1;
            pc_d  = redirect_pc;
`ifdef FETCH_PREFETCH_EN
            pf_busy_d = 1'b0;
`endif
            if (read_req && !bus.mem_ready) begin
                state_d   = FETCH_REQ;
                discard_d = 1'b1;
            end else begin
                state_d   = FETCH_IDLE;
                discard_d = 1'b0;
            end
        end else begin
            if (mem_done) begin
`ifdef FETCH_PREFETCH_EN
                pf_busy_d = 1'b0;
`endif
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    push = 1'b1;
                    pc_d = pc_q + 1'b1;
                end
            end
`ifdef FETCH_PREFETCH_EN
            if (issue_now && !bus.mem_ready) begin
                pf_busy_d = 1'b1;
            end
`endif
            if (handshake) begin
                pop        = 1'b1;
                num_inst_d = num_inst_q + 1'b1;
            end
            next_empty = buf_empty ? !push : (!buf_full && pop && !push);
            case (state_q)
                FETCH_IDLE: if (bus_grant) state_d = FETCH_REQ;
                FETCH_REQ:  if (mem_done) state_d = discard_q ? FETCH_IDLE : FETCH_HOLD;
                FETCH_HOLD: begin
                    if (next_empty) begin
                        state_d = FETCH_IDLE;
`ifdef FETCH_PREFETCH_EN
                        if (pf_busy_d) begin
                            state_d   = FETCH_REQ;
                            pf_busy_d = 1'b0;
                        end
`endif
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            num_inst_q  <= '0;
            discard_q   <= 1'b0;
            halt_pend_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_busy_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            num_inst_q  <= num_inst_d;
            discard_q   <= discard_d;
            halt_pend_q <= halt_pend_d;
`ifdef FETCH_PREFETCH_EN
            pf_busy_q   <= pf_busy_d;
`endif
        end
    end

    fetch_unit_inst_buffer #(.WORD(WORD)) u_inst_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (bus.mem_data),
        .push_pc   (pc_q),
        .head_data (head_data),
        .head_pc   (head_pc),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign bus.readM      = read_req;
    assign bus.address    = read_req ? pc_q : '0;
    assign bus.inst_valid = !buf_empty;
    assign bus.inst       = head_data;
    assign bus.inst_pc    = head_pc;
    assign num_inst       = num_inst_q;
    assign is_halted      = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the basic fetch/stall path plus
// hand-written sequences for redirect, PC wrap, halt and (with FETCH_PREFETCH_EN) prefetch.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, bus_grant, redirect, halt, is_halted;
    logic [15:0] redirect_pc, num_inst;
    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 2;
    int          lat_cnt = 0;

    fetch_unit_if #(.WORD(16)) bus_if ();

    fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_grant   (bus_grant),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .num_inst    (num_inst),
        .is_halted   (is_halted),
        .bus         (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        grant;
        logic        ready;
        logic        exp_readm;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_inst;
        logic [15:0] exp_ipc;
        logic [15:0] exp_num;
    } vec_t;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h6001;
    endfunction

    function automatic vec_t mk(input logic g, input logic r, input logic rm, input logic [15:0] a,
                                input logic v, input logic [15:0] i, input logic [15:0] ip,
                                input logic [15:0] n);
        vec_t t;
        t.grant = g; t.ready = r; t.exp_readm = rm; t.exp_addr = a;
        t.exp_valid = v; t.exp_inst = i; t.exp_ipc = ip; t.exp_num = n;
        return t;
    endfunction

    // Memory model: answers a read after mem_lat cycles of readM, with a one-cycle mem_ready pulse.
    initial begin
        bus_if.mem_ready = 1'b0;
        bus_if.mem_data  = 16'h0000;
        forever begin
            @(posedge clk); #2;
            bus_if.mem_ready = 1'b0;
            if (bus_if.readM === 1'b1) begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_data  = mem_word(bus_if.address);
                    lat_cnt = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        step();
        bus_grant           = v.grant;
        bus_if.inst_ready   = v.ready;
        @(negedge clk);
        checkOutput($sformatf("row%0d.readM", idx), 16'(bus_if.readM), 16'(v.exp_readm));
        checkOutput($sformatf("row%0d.address", idx), bus_if.address, v.exp_addr);
        checkOutput($sformatf("row%0d.inst_valid", idx), 16'(bus_if.inst_valid), 16'(v.exp_valid));
        if (v.exp_valid) begin
            checkOutput($sformatf("row%0d.inst", idx), bus_if.inst, v.exp_inst);
            checkOutput($sformatf("row%0d.inst_pc", idx), bus_if.inst_pc, v.exp_ipc);
        end
        checkOutput($sformatf("row%0d.num_inst", idx), num_inst, v.exp_num);
    endtask

    task automatic doReset();
        reset_n = 1'b0; bus_grant = 1'b0; redirect = 1'b0; halt = 1'b0;
        redirect_pc = 16'h0000; bus_if.inst_ready = 1'b0;
        step();
        @(negedge clk);
        checkOutput("reset.readM", 16'(bus_if.readM), 16'd0);
        checkOutput("reset.address", bus_if.address, 16'h0000);
        checkOutput("reset.inst_valid", 16'(bus_if.inst_valid), 16'd0);
        checkOutput("reset.inst", bus_if.inst, 16'h0000);
        checkOutput("reset.inst_pc", bus_if.inst_pc, 16'h0000);
        checkOutput("reset.num_inst", num_inst, 16'h0000);
        checkOutput("reset.is_halted", 16'(is_halted), 16'd0);
        step();
        reset_n = 1'b1;
    endtask

    task automatic waitReadM(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_if.readM === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic requestUntilValid(input logic [15:0] exp_pc, input string tag, output bit got);
        bit seen_req = 1'b0;
        got = 1'b0;
        step();
        bus_grant = 1'b1;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (bus_if.readM === 1'b1 && !seen_req) begin
                seen_req = 1'b1;
                checkOutput({tag, ".address"}, bus_if.address, exp_pc);
            end
            if (bus_if.inst_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                step();
                if (seen_req) bus_grant = 1'b0;
            end
        end
        checkOutput({tag, ".got_valid"}, 16'(got), 16'd1);
    endtask

    task automatic fetchAndAccept(input logic [15:0] exp_pc, input string tag);
        bit got;
        requestUntilValid(exp_pc, tag, got);
        if (got) begin
            checkOutput({tag, ".inst"}, bus_if.inst, mem_word(exp_pc));
            checkOutput({tag, ".inst_pc"}, bus_if.inst_pc, exp_pc);
            step();
            bus_grant = 1'b0;
            bus_if.inst_ready = 1'b1;
            step();
            bus_if.inst_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [10];
        bit   ok, got, saw_valid, saw_req;
        int   hs, first_cyc, last_cyc;
        logic [15:0] num_before;

        doReset();
`ifndef FETCH_PREFETCH_EN
        // Fetch of word 0 with latency 2, then a five-cycle consumer stall with the bus granted.
        vecs[0] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        vecs[1] = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        vecs[2] = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        vecs[3] = mk(1, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[4] = mk(1, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[5] = mk(1, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[6] = mk(1, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[7] = mk(1, 0, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[8] = mk(0, 1, 0, 16'h0000, 1, 16'h6001, 16'h0000, 16'd0);
        vecs[9] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd1);
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
`else
        fetchAndAccept(16'h0000, "first");
`endif
        fetchAndAccept(16'h0001, "seq1");
        fetchAndAccept(16'h0002, "seq2");
        @(negedge clk);
        checkOutput("seq.num_inst", num_inst, 16'd3);

        // Redirect while the read at pc=3 is outstanding: its data must be dropped.
        mem_lat = 3;
        step();
        bus_grant = 1'b1;
        waitReadM(ok);
        checkOutput("redir.req_seen", 16'(ok), 16'd1);
        if (ok) checkOutput("redir.req_addr", bus_if.address, 16'h0003);
        step();
        bus_grant = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        saw_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus_if.inst_valid === 1'b1) saw_valid = 1'b1;
            step();
        end
        @(negedge clk);
        checkOutput("redir.no_valid", 16'(saw_valid), 16'd0);
        checkOutput("redir.readM_idle", 16'(bus_if.readM), 16'd0);
        checkOutput("redir.num_inst", num_inst, 16'd3);
        fetchAndAccept(16'h0040, "redir.target");

        // Redirect together with inst_ready in HOLD: no count, instruction dropped.
        requestUntilValid(16'h0041, "redir_hold", got);
        step();
        bus_grant = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFF; bus_if.inst_ready = 1'b1;
        step();
        redirect = 1'b0; bus_if.inst_ready = 1'b0;
        @(negedge clk);
        checkOutput("redir_hold.inst_valid", 16'(bus_if.inst_valid), 16'd0);
        checkOutput("redir_hold.num_inst", num_inst, 16'd4);

        // PC wrap from 16'hFFFF to 16'h0000.
        fetchAndAccept(16'hFFFF, "wrap.top");
        fetchAndAccept(16'h0000, "wrap.zero");
        @(negedge clk);
        checkOutput("wrap.num_inst", num_inst, 16'd6);

        // Halt while a read is outstanding: halted after mem_ready, nothing delivered.
        step();
        bus_grant = 1'b1;
        waitReadM(ok);
        checkOutput("halt.req_seen", 16'(ok), 16'd1);
        step();
        bus_grant = 1'b0; halt = 1'b1;
        step();
        halt = 1'b0;
        saw_valid = 1'b0; ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk);
            if (bus_if.inst_valid === 1'b1) saw_valid = 1'b1;
            if (is_halted === 1'b1) ok = 1'b1;
            else step();
        end
        checkOutput("halt.is_halted", 16'(ok), 16'd1);
        checkOutput("halt.no_valid", 16'(saw_valid), 16'd0);
        step();
        redirect = 1'b1; redirect_pc = 16'h0080; bus_grant = 1'b1;
        step();
        redirect = 1'b0;
        saw_req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus_if.readM === 1'b1) saw_req = 1'b1;
            step();
        end
        bus_grant = 1'b0;
        @(negedge clk);
        checkOutput("halt.no_readM", 16'(saw_req), 16'd0);
        checkOutput("halt.still_halted", 16'(is_halted), 16'd1);
        checkOutput("halt.num_inst", num_inst, 16'd6);
        doReset();

        // halt and redirect in the same cycle from IDLE: halt wins.
        step();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0055;
        step();
        halt = 1'b0; redirect = 1'b0;
        @(negedge clk);
        checkOutput("halt_redir.is_halted", 16'(is_halted), 16'd1);
        doReset();
        mem_lat = 2;
        fetchAndAccept(16'h0000, "after_reset");

`ifdef FETCH_PREFETCH_EN
        // Streaming with the consumer always ready: four back-to-back deliveries.
        doReset();
        mem_lat = 1;
        step();
        bus_grant = 1'b1; bus_if.inst_ready = 1'b1;
        hs = 0; first_cyc = 0; last_cyc = 0;
        for (int c = 0; c < 40 && hs < 4; c++) begin
            @(negedge clk);
            if (bus_if.inst_valid === 1'b1) begin
                checkOutput($sformatf("pf.inst%0d", hs), bus_if.inst, mem_word(16'(hs)));
                if (hs == 0) first_cyc = c;
                last_cyc = c;
                hs++;
            end
            step();
        end
        bus_if.inst_ready = 1'b0; bus_grant = 1'b0;
        num_before = num_inst;
        @(negedge clk);
        checkOutput("pf.handshakes", 16'(hs), 16'd4);
        checkOutput("pf.num_inst", num_before, 16'd4);
        checkOutput("pf.back_to_back", 16'(last_cyc - first_cyc), 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
